prim_clock_mux_sel_ctrl: RTL and testbench

- Sequences the select input of a two-input clock mux so that source switching is glitch-safe.
- Accepts a switch request, waits for the target source to report ready, and gates the downstream clock off.
- Flips the mux select, waits for the mux output to settle, re-enables the gate, then acknowledges.
- Sits in the clock manager beside the mux and the downstream clock gate. Runs on one always-on control clock.

---
 rtl/prim_clock_mux_sel_ctrl.sv | 174 +++++++++++++++++
 tb/tb_prim_clock_mux_sel_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_clock_mux_sel_ctrl.sv
// prim_clock_mux_sel_ctrl
// Sequences the select line of a two-input clock mux so that a source
// switch never produces a glitch downstream. A switch request waits for
// the target source to be ready, gates the downstream clock off, flips
// the select, lets the mux output settle and then re-opens the gate and
// acknowledges. Everything runs on the always-on control clock clk_i.
//
// Timing of a switch whose request is sampled at edge E (target ready):
//   edge E             : GATE_OFF entered, busy_o rises
//   edges E+1..        : cg_en_o low (GateDelay cycles with the old select)
//   edge E+GateDelay+1 : sel_o flips, SETTLE entered
//   edge E+GateDelay+SettleDelay+1 : cg_en_o high again, ack_o pulses
//
// GateDelay, SettleDelay and TimeoutCycles must all be >= 1.

module prim_clock_mux_sel_ctrl #(
  parameter int unsigned GateDelay     = 4,
  parameter int unsigned SettleDelay   = 8,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic       req_sel_i,
  input  logic [1:0] clk_ok_i,
  output logic       ack_o,
  output logic       err_o,
  output logic       sel_o,
  output logic       cg_en_o,
  output logic       busy_o
);

  // The one counter is shared by the gate, settle and timeout phases, so
  // it has to hold the largest of the three delays.
  localparam int unsigned MaxGateSettle =
      (GateDelay > SettleDelay) ? GateDelay : SettleDelay;
  localparam int unsigned MaxDelay =
      (MaxGateSettle > TimeoutCycles) ? MaxGateSettle : TimeoutCycles;
  localparam int unsigned CntW = $clog2(MaxDelay + 1);

  // Terminal counts for each phase. GATE_OFF spends its first cycle
  // registering the gate-off, so it ends one count later than SETTLE.
  localparam logic [CntW-1:0] GateLast    = CntW'(GateDelay);
  localparam logic [CntW-1:0] SettleLast  = CntW'(SettleDelay - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax      = {CntW{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    WAIT_OK,
    GATE_OFF,
    SETTLE,
    DONE
  } state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic            tgt;

  // Saturating increment: the counter parks at its maximum instead of
  // wrapping back to a value that could re-match a terminal count.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] value);
    return (value == CntMax) ? value : value + CntW'(1);
  endfunction

  // Switch sequencer: state, shared counter, captured target and all outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      tgt     <= 1'b0;
      sel_o   <= 1'b0;
      cg_en_o <= 1'b1;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;

      case (state)
        IDLE: begin
          // A timeout acknowledge is still visible during the first IDLE
          // cycle; ignoring requests then keeps an IDLE gap after every ack.
          if (req_i && !ack_o) begin
            tgt    <= req_sel_i;
            cnt    <= '0;
            busy_o <= 1'b1;
            if (req_sel_i == sel_o) begin
              state <= DONE;
              ack_o <= 1'b1;
            end else if (clk_ok_i[req_sel_i]) begin
              state <= GATE_OFF;
            end else begin
              state <= WAIT_OK;
            end
          end
        end

        WAIT_OK: begin
          if (clk_ok_i[tgt]) begin
            state <= GATE_OFF;
            cnt   <= '0;
          end else if (cnt == TimeoutLast) begin
            state  <= IDLE;
            cnt    <= '0;
            ack_o  <= 1'b1;
            err_o  <= 1'b1;
            busy_o <= 1'b0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        GATE_OFF: begin
          cg_en_o <= 1'b0;
          if (cnt == GateLast) begin
            sel_o <= tgt;
            state <= SETTLE;
            cnt   <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        SETTLE: begin
          if (cnt == SettleLast) begin
            state   <= DONE;
            cnt     <= '0;
            cg_en_o <= 1'b1;
            ack_o   <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        DONE: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_o <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          cg_en_o <= 1'b1;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // An acknowledge while busy is only legal as the DONE completion pulse.
  ack_busy_only_in_done : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (ack_o && busy_o) |-> (state == DONE)
  );

  // An error is always reported as part of an acknowledge.
  err_implies_ack : assert property (
    @(posedge clk_i) disable iff (rst_i)
    err_o |-> ack_o
  );

  // The select may only move while the downstream gate is closed on both
  // sides of the change; a reset-forced return to 0 is exempt.
  sel_change_gated : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (!$past(rst_i) && (sel_o != $past(sel_o))) |-> (!cg_en_o && !$past(cg_en_o))
  );
`endif

endmodule

// File: tb/tb_prim_clock_mux_sel_ctrl.sv
// tb_prim_clock_mux_sel_ctrl
// Self-checking bench: a hand-derived vector table, directed sequences for
// wait/timeout/reset corners, then randomized traffic compared cycle by
// cycle against a timestamp-based reference model.

module tb_prim_clock_mux_sel_ctrl;

  localparam int GateDly    = 4;
  localparam int SettleDly  = 8;
  localparam int TimeoutCyc = 256;
  localparam int NumVecs    = 36;
  localparam int RandCycles = 4000;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_i;
  logic       req_sel_i;
  logic [1:0] clk_ok_i;
  logic       ack_o;
  logic       err_o;
  logic       sel_o;
  logic       cg_en_o;
  logic       busy_o;

  prim_clock_mux_sel_ctrl #(
    .GateDelay    (GateDly),
    .SettleDelay  (SettleDly),
    .TimeoutCycles(TimeoutCyc)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .req_sel_i(req_sel_i),
    .clk_ok_i (clk_ok_i),
    .ack_o    (ack_o),
    .err_o    (err_o),
    .sel_o    (sel_o),
    .cg_en_o  (cg_en_o),
    .busy_o   (busy_o)
  );

  // Free-running control clock.
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic       req;
    logic       rsel;
    logic [1:0] ok;
    logic       eSel;
    logic       eCg;
    logic       eAck;
    logic       eErr;
    logic       eBusy;
  } vecT;

  vecT vecs[NumVecs];

  int errCount   = 0;
  int checkCount = 0;
  int edgeNum    = 0;

  // Reference model: one outstanding request described by timestamps.
  logic mSel    = 1'b0;
  logic pend    = 1'b0;
  logic pNoop   = 1'b0;
  logic pTgt    = 1'b0;
  int   pE      = 0;
  int   pS      = -1;
  int   nextAcc = 0;
  logic eSel, eCg, eAck, eErr, eBusy;

  logic prevSel = 1'b0;
  logic prevCg  = 1'b1;

  // Tally one comparison and report it if it disagrees.
  task automatic checkInt(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeNum);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %b, expected %b (edge %0d)", name, actual, expected, edgeNum);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic req, input logic rsel,
                               input logic [1:0] ok);
    rst_i     = rst;
    req_i     = req;
    req_sel_i = rsel;
    clk_ok_i  = ok;
  endtask

  task automatic setVec(input int i, input int rst, input int req, input int rsel, input int ok,
                        input int s, input int c, input int a, input int e, input int b);
    vecs[i].rst   = 1'(rst);
    vecs[i].req   = 1'(req);
    vecs[i].rsel  = 1'(rsel);
    vecs[i].ok    = 2'(ok);
    vecs[i].eSel  = 1'(s);
    vecs[i].eCg   = 1'(c);
    vecs[i].eAck  = 1'(a);
    vecs[i].eErr  = 1'(e);
    vecs[i].eBusy = 1'(b);
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled,
  // and derive the outputs expected right after that edge.
  task automatic modelEdge();
    int n;
    int ackEdge;
    n = edgeNum;
    if (rst_i) begin
      mSel    = 1'b0;
      pend    = 1'b0;
      nextAcc = n + 1;
    end else begin
      if (pend) begin
        if (pNoop) begin
          if (n > pE) pend = 1'b0;
        end else if (pS >= 0) begin
          if (n > pS + GateDly + SettleDly + 1) begin
            pend = 1'b0;
            mSel = pTgt;
          end
        end else if (n > pE + TimeoutCyc) begin
          pend = 1'b0;
        end
      end
      if (!pend) begin
        if (req_i && n >= nextAcc) begin
          pend  = 1'b1;
          pE    = n;
          pTgt  = req_sel_i;
          pNoop = (req_sel_i == mSel);
          pS    = (!pNoop && clk_ok_i[req_sel_i]) ? n : -1;
        end
      end else if (!pNoop && pS < 0 && n <= pE + TimeoutCyc && clk_ok_i[pTgt]) begin
        pS = n;
      end
    end

    eSel  = mSel;
    eCg   = 1'b1;
    eAck  = 1'b0;
    eErr  = 1'b0;
    eBusy = 1'b0;
    if (pend) begin
      if (pNoop) begin
        eAck    = (n == pE);
        eBusy   = (n == pE);
        nextAcc = pE + 2;
      end else if (pS >= 0) begin
        ackEdge = pS + GateDly + SettleDly + 1;
        eCg     = !(n >= pS + 1 && n <= ackEdge - 1);
        eSel    = (n >= pS + GateDly + 1) ? pTgt : mSel;
        eAck    = (n == ackEdge);
        eBusy   = (n <= ackEdge);
        nextAcc = ackEdge + 2;
      end else if (n >= pE + TimeoutCyc) begin
        eAck    = (n == pE + TimeoutCyc);
        eErr    = (n == pE + TimeoutCyc);
        nextAcc = pE + TimeoutCyc + 2;
      end else begin
        eBusy = 1'b1;
      end
    end
  endtask

  // One clock: update the model at the edge, compare just after it.
  task automatic tick();
    @(posedge clk_i);
    modelEdge();
    #1;
    checkBit("sel", sel_o, eSel);
    checkBit("cg_en", cg_en_o, eCg);
    checkBit("ack", ack_o, eAck);
    checkBit("err", err_o, eErr);
    checkBit("busy", busy_o, eBusy);
    if (!rst_i && (sel_o != prevSel))
      checkInt("sel_flip_gated", int'({prevCg, cg_en_o}), 0);
    prevSel = sel_o;
    prevCg  = cg_en_o;
    edgeNum++;
  endtask

  // Global time bound so the bench can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int  k;
    logic nReq, nSel;
    logic [1:0] okv;
    int  mode;

    // Vector table: reset, no-op switch, 0->1 switch, immediate 1->0 switch.
    setVec(0, 1, 0, 0, 3, 0, 1, 0, 0, 0);
    setVec(1, 1, 0, 0, 3, 0, 1, 0, 0, 0);
    setVec(2, 0, 0, 0, 3, 0, 1, 0, 0, 0);
    setVec(3, 0, 1, 0, 3, 0, 1, 1, 0, 1);
    setVec(4, 0, 0, 0, 3, 0, 1, 0, 0, 0);
    setVec(5, 0, 0, 0, 3, 0, 1, 0, 0, 0);
    setVec(6, 0, 1, 1, 3, 0, 1, 0, 0, 1);
    for (int i = 7; i <= 10; i++) setVec(i, 0, 1, 1, 3, 0, 0, 0, 0, 1);
    for (int i = 11; i <= 18; i++) setVec(i, 0, 1, 1, 3, 1, 0, 0, 0, 1);
    setVec(19, 0, 1, 1, 3, 1, 1, 1, 0, 1);
    setVec(20, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    setVec(21, 0, 1, 0, 1, 1, 1, 0, 0, 1);
    for (int i = 22; i <= 25; i++) setVec(i, 0, 1, 0, 1, 1, 0, 0, 0, 1);
    for (int i = 26; i <= 33; i++) setVec(i, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    setVec(34, 0, 1, 0, 1, 0, 1, 1, 0, 1);
    setVec(35, 0, 0, 0, 1, 0, 1, 0, 0, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 2'b11);
    for (int i = 0; i < NumVecs; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].rsel, vecs[i].ok);
      tick();
      checkBit($sformatf("vec%0d_sel", i), sel_o, vecs[i].eSel);
      checkBit($sformatf("vec%0d_cg_en", i), cg_en_o, vecs[i].eCg);
      checkBit($sformatf("vec%0d_ack", i), ack_o, vecs[i].eAck);
      checkBit($sformatf("vec%0d_err", i), err_o, vecs[i].eErr);
      checkBit($sformatf("vec%0d_busy", i), busy_o, vecs[i].eBusy);
    end

    // Timeout: clk1 never becomes ready.
    $display("[TB] timeout sequence");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01);
    tick();
    k = 0;
    for (int i = 1; i <= TimeoutCyc + 20; i++) begin
      tick();
      if (ack_o) begin
        k = i;
        break;
      end
      checkBit("timeout_cg_hold", cg_en_o, 1'b1);
      checkBit("timeout_sel_hold", sel_o, 1'b0);
    end
    checkInt("timeout_latency", k, TimeoutCyc);
    checkBit("timeout_err", err_o, 1'b1);
    checkBit("timeout_sel", sel_o, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
    tick();
    checkBit("timeout_ack_pulse", ack_o, 1'b0);
    checkBit("timeout_err_pulse", err_o, 1'b0);
    tick();

    // Reset while settling after the select has already flipped.
    $display("[TB] reset-in-settle sequence");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11);
    tick();
    repeat (7) tick();
    checkBit("settle_sel", sel_o, 1'b1);
    checkBit("settle_cg_en", cg_en_o, 1'b0);
    checkBit("settle_busy", busy_o, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b11);
    tick();
    checkBit("rst_sel", sel_o, 1'b0);
    checkBit("rst_cg_en", cg_en_o, 1'b1);
    checkBit("rst_busy", busy_o, 1'b0);
    checkBit("rst_ack", ack_o, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b11);
    for (int i = 0; i < 16; i++) begin
      tick();
      checkBit("rst_no_ack", ack_o, 1'b0);
    end

    // Target not ready for 10 cycles, then ready.
    $display("[TB] wait-for-ready sequence");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01);
    tick();
    repeat (10) begin
      tick();
      checkBit("wait_cg_en", cg_en_o, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11);
    tick();
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (ack_o) begin
        k = i;
        break;
      end
    end
    checkInt("wait_ack_latency", k, GateDly + SettleDly + 1);
    checkBit("wait_err", err_o, 1'b0);
    checkBit("wait_sel", sel_o, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11);
    tick();
    checkBit("wait_ack_pulse", ack_o, 1'b0);

    // Randomized traffic against the reference model.
    $display("[TB] random sequence");
    mode = 1;
    for (int c = 0; c < RandCycles; c++) begin
      if (c % 60 == 0) mode = int'($urandom_range(0, 2));
      nReq = req_i;
      nSel = req_sel_i;
      if (ack_o) begin
        if ($urandom_range(0, 3) == 0) begin
          nReq = 1'b1;
          nSel = 1'($urandom_range(0, 1));
        end else begin
          nReq = 1'b0;
        end
      end else if (!req_i) begin
        if ($urandom_range(0, 2) == 0) begin
          nReq = 1'b1;
          nSel = 1'($urandom_range(0, 1));
        end
      end else if ($urandom_range(0, 299) == 0) begin
        nReq = 1'b0;
      end
      case (mode)
        0:       okv = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
        1:       okv = 2'b11;
        default: okv = 2'b00;
      endcase
      applyStimulus(($urandom_range(0, 399) == 0), nReq, nSel, okv);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
